// File: rtl/fe_pkg.sv
// fe_pkg: stall codes and the {pc, isn} entry type shared by the fetch/decode instruction buffer
package fe_pkg;
    localparam logic [1:0] CTR_STALL = 2'b10;
    localparam logic [1:0] CTR_RUN   = 2'b00;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] isn;
    } fe_entry_t;
endpackage

// File: rtl/fe_ibuf_ram.sv
// fe_ibuf_ram: DEPTH x 64 register file, one write port, one asynchronous read port
module fe_ibuf_ram
    import fe_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fe_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output fe_entry_t     rdata
);
    fe_entry_t mem [DEPTH];
    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/fe_ibuf.sv
// fe_ibuf: fetch-side instruction buffer with stall code to fetch and valid/ready to decode.
// Define FE_IBUF_BYPASS_EN to forward the fetch pair straight to decode when the buffer is empty.
module fe_ibuf
    import fe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      fe_pc,
    input  logic [31:0]      fe_isn,
    output logic [1:0]       ctr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_isn,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          stall, byp, enq, deq;
    fe_entry_t     head, din;
    assign din = '{pc: fe_pc, isn: fe_isn};
    fe_ibuf_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (enq),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (head)
    );
    // ctr depends only on registered occupancy, never on out_ready.
    always_comb begin
        stall = count == FULL;
        ctr = stall ? CTR_STALL : CTR_RUN;
`ifdef FE_IBUF_BYPASS_EN
        byp = count == '0;
`else
        byp = 1'b0;
`endif
        out_valid = count != '0 || byp;
        out_pc = byp ? fe_pc : head.pc;
        out_isn = byp ? fe_isn : head.isn;
        enq = !stall && !(byp && out_ready);
        deq = count != '0 && out_ready;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            stall_cycles <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(enq);
            rd_ptr <= rd_ptr + AW'(deq);
            count <= count + (AW+1)'(enq) - (AW+1)'(deq);
            stall_cycles <= stall_cycles + CNT_W'(stall && !(&stall_cycles));
        end
    end
endmodule
